// File: rtl/safety_pkg.sv
// Shared types and constants for the laser safety interlock.
// Fault vector bit positions follow the limit checker's fail outputs.
package safety_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    TRIPPED  = 2'd2,
    CLEARING = 2'd3
  } interlock_state_t;

  localparam int FLT_PW_LO    = 0;
  localparam int FLT_PW_HI    = 1;
  localparam int FLT_RATE     = 2;
  localparam int FLT_CURR     = 3;
  localparam int NUM_FAULTS   = 4;
  localparam int TRIP_COUNT_W = 16;

  function automatic logic [TRIP_COUNT_W-1:0] sat_inc(input logic [TRIP_COUNT_W-1:0] v);
    logic [TRIP_COUNT_W-1:0] r;
    if (v == {TRIP_COUNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(TRIP_COUNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/safety_interlock_if.sv
// Fault inputs, operator requests and status outputs of the interlock.
// The slave modport is the interlock itself; master is whoever drives it.
interface safety_interlock_if;
  import safety_pkg::*;

  logic                    pulse_lower_limit_fail;
  logic                    pulse_upper_limit_fail;
  logic                    rate_lower_limit_fail;
  logic                    current_limit_fail;
  logic                    arm_req;
  logic                    disarm_req;
  logic                    clear_req;
  logic                    laser_enable;
  logic                    clear_fail;
  logic [NUM_FAULTS-1:0]   fault_status;
  logic [NUM_FAULTS-1:0]   first_fault;
  logic [TRIP_COUNT_W-1:0] trip_count;
  logic [1:0]              state;

  modport slave (
    input  pulse_lower_limit_fail, pulse_upper_limit_fail,
           rate_lower_limit_fail, current_limit_fail,
           arm_req, disarm_req, clear_req,
    output laser_enable, clear_fail, fault_status, first_fault,
           trip_count, state
  );

  modport master (
    output pulse_lower_limit_fail, pulse_upper_limit_fail,
           rate_lower_limit_fail, current_limit_fail,
           arm_req, disarm_req, clear_req,
    input  laser_enable, clear_fail, fault_status, first_fault,
           trip_count, state
  );

endinterface

// File: rtl/safety_interlock_timer.sv
// Loadable down-counter shared by the clear-pulse and re-arm holdoff phases.
// done is high while the count sits at zero; loading N gives N+1 cycles to done.
module interlock_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_r;

  // Count register: load wins, otherwise decrement down to zero and hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/safety_interlock.sv
// Laser enable authority: arms, trips within one clock of any fail, records
// fault history and drives the clear handshake with a fault-free holdoff.
module safety_interlock
  import safety_pkg::*;
#(
  parameter int CLEAR_PULSE_CYCLES = 4,
  parameter int REARM_HOLDOFF      = 1000
) (
  input  logic               clk,
  input  logic               rstn,
  safety_interlock_if.slave  bus
);

  localparam int MAX_CNT = (CLEAR_PULSE_CYCLES > REARM_HOLDOFF) ? CLEAR_PULSE_CYCLES : REARM_HOLDOFF;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(CLEAR_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(REARM_HOLDOFF - 1);

  interlock_state_t        state_r, next_state_s;
  logic [NUM_FAULTS-1:0]   fails_s;
  logic                    laser_enable_r;
  logic                    clear_fail_r;
  logic [NUM_FAULTS-1:0]   fault_status_r;
  logic [NUM_FAULTS-1:0]   first_fault_r;
  logic [TRIP_COUNT_W-1:0] trip_count_r;
  logic                    timer_load_s;
  logic [CNT_W-1:0]        timer_val_s;
  logic                    timer_done_s;
  logic                    enter_clear_s;
  logic                    enter_hold_s;
  logic                    trip_s;
  logic                    clean_s;

  assign fails_s[FLT_PW_LO] = bus.pulse_lower_limit_fail;
  assign fails_s[FLT_PW_HI] = bus.pulse_upper_limit_fail;
  assign fails_s[FLT_RATE]  = bus.rate_lower_limit_fail;
  assign fails_s[FLT_CURR]  = bus.current_limit_fail;

  interlock_timer #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .done     (timer_done_s)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= DISARMED;
    end else begin
      state_r <= next_state_s;
    end
  end

  // clear_fail_r doubles as the pulse-phase flag while in CLEARING.
  always_comb begin
    next_state_s  = state_r;
    timer_load_s  = 1'b0;
    timer_val_s   = {CNT_W{1'b0}};
    enter_clear_s = 1'b0;
    enter_hold_s  = 1'b0;
    trip_s        = 1'b0;
    clean_s       = 1'b0;
    case (state_r)
      DISARMED: begin
        if (bus.arm_req && (fault_status_r == 4'b0000) && (fails_s == 4'b0000)) begin
          next_state_s = ARMED;
        end else if (bus.clear_req) begin
          next_state_s  = CLEARING;
          enter_clear_s = 1'b1;
          timer_load_s  = 1'b1;
          timer_val_s   = PULSE_LOAD;
        end else begin
          next_state_s = DISARMED;
        end
      end
      ARMED: begin
        if (fails_s != 4'b0000) begin
          next_state_s = TRIPPED;
          trip_s       = 1'b1;
        end else if (bus.disarm_req) begin
          next_state_s = DISARMED;
        end else begin
          next_state_s = ARMED;
        end
      end
      TRIPPED: begin
        if (bus.clear_req) begin
          next_state_s  = CLEARING;
          enter_clear_s = 1'b1;
          timer_load_s  = 1'b1;
          timer_val_s   = PULSE_LOAD;
        end else begin
          next_state_s = TRIPPED;
        end
      end
      CLEARING: begin
        if (clear_fail_r) begin
          if (timer_done_s) begin
            enter_hold_s = 1'b1;
            timer_load_s = 1'b1;
            timer_val_s  = HOLD_LOAD;
          end else begin
            enter_hold_s = 1'b0;
          end
        end else if (fails_s != 4'b0000) begin
          next_state_s = TRIPPED;
        end else if (timer_done_s) begin
          next_state_s = DISARMED;
          clean_s      = 1'b1;
        end else begin
          next_state_s = CLEARING;
        end
      end
      default: begin
        next_state_s = DISARMED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      laser_enable_r <= 1'b0;
      clear_fail_r   <= 1'b0;
      fault_status_r <= 4'b0000;
      first_fault_r  <= 4'b0000;
      trip_count_r   <= {TRIP_COUNT_W{1'b0}};
    end else begin
      laser_enable_r <= (next_state_s == ARMED);

      if (enter_clear_s) begin
        clear_fail_r <= 1'b1;
      end else if (enter_hold_s) begin
        clear_fail_r <= 1'b0;
      end else begin
        clear_fail_r <= clear_fail_r;
      end

      if (clean_s) begin
        fault_status_r <= 4'b0000;
      end else if (!clear_fail_r) begin
        fault_status_r <= fault_status_r | fails_s;
      end else begin
        fault_status_r <= fault_status_r;
      end

      if (trip_s) begin
        first_fault_r <= fails_s;
        trip_count_r  <= sat_inc(trip_count_r);
      end else if (clean_s) begin
        first_fault_r <= 4'b0000;
        trip_count_r  <= trip_count_r;
      end else begin
        first_fault_r <= first_fault_r;
        trip_count_r  <= trip_count_r;
      end
    end
  end

  assign bus.laser_enable = laser_enable_r;
  assign bus.clear_fail   = clear_fail_r;
  assign bus.fault_status = fault_status_r;
  assign bus.first_fault  = first_fault_r;
  assign bus.trip_count   = trip_count_r;
  assign bus.state        = state_r;

endmodule

// File: doc/safety_interlock.md
# safety_interlock

Downstream consumer of the four limit-check fail flags: arms and gates the laser enable, trips it off within one clock of any fail, and records which fault occurred first, the accumulated set of faults, and a saturating trip count. It also generates the `clear_fail` pulse back to the limit checker and requires a fault-free holdoff before the system returns to DISARMED. This block is the single authority for `laser_enable` in the safety FPGA.

## Interface
Parameters:
- `CLEAR_PULSE_CYCLES`, default 4: width of the `clear_fail` pulse. Legal range ≥1.
- `REARM_HOLDOFF`, default 1000: number of fault-free cycles required after the clear pulse. Legal range ≥1.

Ports:
- `clk`  in  1  system clock; the block is single-clock.
- `rstn`  in  1  reset, asynchronous and active-low.
- `pulse_lower_limit_fail`  in  1  fault vector bit [0].
- `pulse_upper_limit_fail`  in  1  fault vector bit [1].
- `rate_lower_limit_fail`  in  1  fault vector bit [2].
- `current_limit_fail`  in  1  fault vector bit [3].
- `arm_req`  in  1  single-cycle request to arm.
- `disarm_req`  in  1  single-cycle request to disarm.
- `clear_req`  in  1  single-cycle request to clear faults.
- `laser_enable`  out  1  laser gate; registered.
- `clear_fail`  out  1  clear pulse to the limit checker.
- `fault_status`  out  4  sticky OR of all fail bits seen.
- `first_fault`  out  4  fail vector captured at the trip.
- `trip_count`  out  16  number of trips; saturates at 0xFFFF.
- `state`  out  2  0 DISARMED, 1 ARMED, 2 TRIPPED, 3 CLEARING.

## Operation
- In this section, `fails` means the 4-bit vector formed from the fail inputs above.
- **Reset:** `state`=DISARMED. All outputs are 0.
- **DISARMED:** `laser_enable`=0.
  - `arm_req` with `fault_status`==0 and `fails`==0: go to ARMED. Otherwise `arm_req` is ignored.
  - `clear_req`: go to CLEARING. If `arm_req` and `clear_req` arrive together, arm takes priority when it is legal.
- **ARMED:** `laser_enable`=1.
  - `fails`≠0: go to TRIPPED. Capture `first_fault`=`fails`; more than one bit may be set. Increment `trip_count`, saturating.
  - Otherwise, `disarm_req`: go to DISARMED. A fail arriving in the same cycle as `disarm_req` wins (TRIPPED).
  - `clear_req` is ignored.
- **TRIPPED:** `laser_enable`=0. `clear_req`: go to CLEARING. `arm_req` and `disarm_req` are ignored.
- **CLEARING:** two phases run on a shared down-counter.
  - Pulse phase: `clear_fail`=1 for exactly `CLEAR_PULSE_CYCLES` cycles. `fails` is not sampled in this phase.
  - Holdoff phase: lasts `REARM_HOLDOFF` cycles. Any `fails`≠0 during holdoff goes to TRIPPED immediately. `first_fault` and `trip_count` are unchanged on this transition.
  - Holdoff expires clean: clear `fault_status` and `first_fault`, then go to DISARMED.
  - `clear_req`, `arm_req` and `disarm_req` are ignored in CLEARING.
- **fault_status:** `fault_status |= fails` every cycle, except during the pulse phase.
- **trip_count:** increments only on the ARMED→TRIPPED transition. It is cleared only by reset.

## Timing
- Fail sampled high at edge N while ARMED → `laser_enable` reads 0 after edge N. Latency is 1 clock, and no combinational path exists from fail inputs to `laser_enable`.
- `clear_fail` rises on the edge that enters CLEARING. It is high for exactly `CLEAR_PULSE_CYCLES` cycles, then low.
- Clean clear: total time in CLEARING is `CLEAR_PULSE_CYCLES`+`REARM_HOLDOFF` cycles.
- `arm_req` → `laser_enable`=1 one clock later.
- All outputs are registered.
- `rstn` asserted at any point, including mid-CLEARING: all outputs drop to 0 asynchronously and the counters reset.
- Counter width is `$clog2(max(CLEAR_PULSE_CYCLES, REARM_HOLDOFF)+1)`.

## Structure
- Package `safety_pkg` holds:
  - `interlock_state_t` (2-bit enum: DISARMED, ARMED, TRIPPED, CLEARING).
  - Fault index localparams `FLT_PW_LO`=0, `FLT_PW_HI`=1, `FLT_RATE`=2, `FLT_CURR`=3.
  - `TRIP_COUNT_W`=16.
- Sub-module `interlock_timer`: a loadable down-counter with a `done` flag, reused for the pulse phase and the holdoff phase.
- The FSM, fault latches and `trip_count` live in the top module.

## Test plan
- **Arm and trip on current.** Reset, pulse `arm_req`, then assert `current_limit_fail` at cycle 10.
  - Required: `laser_enable` is 0 at cycle 11, `state`=2, `first_fault`=4'b1000, `trip_count`=1.
- **Clean clear.** Defaults. From TRIPPED, pulse `clear_req` with fails dropping when `clear_fail` rises.
  - Required: `clear_fail` high for 4 cycles; after 1004 cycles `state`=0 and `fault_status`=0.
- **Fault during holdoff.** Re-assert `rate_lower_limit_fail` 200 cycles into the holdoff.
  - Required: `state`=2 the next cycle, `fault_status[2]`=1, `trip_count` unchanged.
- **Simultaneous fails.** Assert `pulse_lower_limit_fail` and `pulse_upper_limit_fail` together with `disarm_req`.
  - Required: TRIPPED, `first_fault`=4'b0011.
- **Arm blocked.** Send `arm_req` while `fault_status`≠0 or any fail is high.
  - Required: `state` stays 0 and `laser_enable` stays 0.
- **Reset mid-clear and saturation.**
  - Assert `rstn` low mid-holdoff. Required: all outputs are 0 immediately.
  - Force 65536 trips. Required: `trip_count`=0xFFFF.
